// File: rtl/conv2d_stream_pkg.sv
// Shared types and width helpers for the conv2d_stream block.
package conv2d_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int addr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int k);
        return dw + cw + 1 + clog2(k * k);
    endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Pixel-in, result-out and coefficient-write bundle for conv2d_stream.
interface conv2d_stream_if #(
    parameter int KSIZE      = 3,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8
) ();
    import conv2d_stream_pkg::*;

    localparam int COEF_AW = addr_width(KSIZE * KSIZE);
    localparam int ACC_W   = acc_width(DATA_WIDTH, COEF_WIDTH, KSIZE);

    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        in_data;
    logic                         in_sof;
    logic                         coef_we;
    logic [COEF_AW-1:0]           coef_addr;
    logic signed [COEF_WIDTH-1:0] coef_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [ACC_W-1:0]      out_data;
    logic                         frame_done;

    modport master (
        output in_valid, in_data, in_sof, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_sof, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data, frame_done
    );

endinterface

// File: rtl/conv2d_stream_linebuf.sv
// One image line of pixel storage; read and written at the same column per accepted pixel.
module conv2d_linebuf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the pixel from one line earlier before this cycle's write replaces it.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KSIZE x KSIZE 2D convolution over a row-major pixel stream.
// Optional build macro CONV2D_RELU_EN clamps negative results to zero.
module conv2d_stream #(
    parameter int NUM_COL    = 8,
    parameter int NUM_ROW    = 6,
    parameter int KSIZE      = 3,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    conv2d_stream_if.slave bus
);
    import conv2d_stream_pkg::*;

    localparam int NTAP  = KSIZE * KSIZE;
    localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, KSIZE);
    localparam int COL_W = addr_width(NUM_COL);
    localparam int ROW_W = addr_width(NUM_ROW);

    state_t                       state;
    logic [COL_W-1:0]             col;
    logic [ROW_W-1:0]             row;
    logic [COL_W-1:0]             eff_col;
    logic [ROW_W-1:0]             eff_row;
    logic [DATA_WIDTH-1:0]        win      [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0]        next_win [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0]        col_vec  [KSIZE];
    logic [DATA_WIDTH-1:0]        lb_rd    [KSIZE-1];
    logic signed [COEF_WIDTH-1:0] coef     [NTAP];
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      pix_ext;
    logic signed [ACC_W-1:0]      coef_ext;
    logic signed [ACC_W-1:0]      result;
    logic signed [ACC_W-1:0]      out_data_q;
    logic                         out_valid_q;
    logic                         out_last;
    logic                         accept;
    logic                         proc;
    logic                         produce;
    logic                         last_pix;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    // A start-of-frame pixel is always processed as (0,0), whatever the counters say.
    assign proc           = accept && (state == ACTIVE || bus.in_sof);
    assign eff_col        = bus.in_sof ? '0 : col;
    assign eff_row        = bus.in_sof ? '0 : row;
    assign last_pix       = (eff_row == ROW_W'(NUM_ROW - 1)) && (eff_col == COL_W'(NUM_COL - 1));
    assign produce        = proc && (eff_row >= ROW_W'(KSIZE - 1)) && (eff_col >= COL_W'(KSIZE - 1));

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = out_valid_q && bus.out_ready && out_last;

    genvar m;
    generate
        for (m = 0; m < KSIZE - 1; m++) begin : g_lb
            logic [DATA_WIDTH-1:0] wr_data;
            if (m == 0) begin : g_first
                assign wr_data = bus.in_data;
            end else begin : g_chain
                assign wr_data = lb_rd[m-1];
            end
            conv2d_linebuf #(
                .DEPTH (NUM_COL),
                .WIDTH (DATA_WIDTH),
                .AW    (COL_W)
            ) u_linebuf (
                .clk     (clk),
                .wr_en   (proc),
                .addr    (eff_col),
                .wr_data (wr_data),
                .rd_data (lb_rd[m])
            );
        end
    endgenerate

    // Incoming column: the newest pixel at the bottom, older lines stacked above it.
    always_comb begin
        for (int i = 0; i < KSIZE; i++) begin
            col_vec[i] = '0;
        end
        col_vec[KSIZE-1] = bus.in_data;
        for (int k = 0; k < KSIZE - 1; k++) begin
            col_vec[KSIZE-2-k] = lb_rd[k];
        end
    end

    always_comb begin
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE - 1; j++) begin
                next_win[i][j] = bus.in_sof ? '0 : win[i][j+1];
            end
            next_win[i][KSIZE-1] = col_vec[i];
        end
    end

    always_comb begin
        acc      = '0;
        pix_ext  = '0;
        coef_ext = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                pix_ext  = ACC_W'(next_win[i][j]);
                coef_ext = ACC_W'(coef[i*KSIZE+j]);
                acc      = acc + pix_ext * coef_ext;
            end
        end
    end

`ifdef CONV2D_RELU_EN
    assign result = acc[ACC_W-1] ? '0 : acc;
`else
    assign result = acc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last    <= 1'b0;
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            if (proc) begin
                win <= next_win;
                if (last_pix) begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    state <= ACTIVE;
                    if (eff_col == COL_W'(NUM_COL - 1)) begin
                        col <= '0;
                        row <= eff_row + ROW_W'(1);
                    end else begin
                        col <= eff_col + COL_W'(1);
                        row <= eff_row;
                    end
                end
            end
            // Acceptance implies the output slot is free, so a new result never overwrites one.
            if (produce) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
                out_last    <= last_pix;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAP; k++) begin
                coef[k] <= '0;
            end
        end else if (bus.coef_we && state == IDLE && int'(bus.coef_addr) < NTAP) begin
            coef[bus.coef_addr] <= bus.coef_data;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: vector table plus reset/abort sequences against a frame model.
module tb_conv2d_stream;
    import conv2d_stream_pkg::*;

    localparam int NC   = 8;
    localparam int NR   = 6;
    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int NTAP = K * K;
    localparam int AW   = addr_width(NTAP);

    typedef struct {
        string name;
        int    coef_mode;
        int    pix_mode;
        int    rnd_ready;
        int    junk;
        int    restart;
        int    midwrite;
        int    exp_count;
        int    exp_fd;
        int    fixed;
        int    exp_first;
        int    exp_last;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    int   img [NR][NC];
    int   cf  [NTAP];
    int   exp_q [$];
    bit   collecting = 1'b0;
    bit   rand_ready = 1'b0;
    bit   ready_level = 1'b0;
    int   got_cnt, fd_cnt, first_val, last_val;
    vec_t vecs [6];

    conv2d_stream_if #(.KSIZE(K), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus ();

    conv2d_stream #(
        .NUM_COL    (NC),
        .NUM_ROW    (NR),
        .KSIZE      (K),
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Reference: direct window sums over the stored frame, no padding.
    function automatic void buildExpected();
        int s;
        exp_q.delete();
        for (int r = K - 1; r < NR; r++) begin
            for (int c = K - 1; c < NC; c++) begin
                s = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s += img[r-K+1+i][c-K+1+j] * cf[i*K+j];
`ifdef CONV2D_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_q.push_back(s);
            end
        end
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    always @(negedge clk) begin : monitor
        int act;
        if (collecting && reset) begin
            if (bus.out_valid && bus.out_ready) begin
                act = bus.out_data;
                if (got_cnt == 0) first_val = act;
                last_val = act;
                got_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: actual=%0d required=none", act);
                end else begin
                    checkOutput("frame_done_timing", int'(bus.frame_done), (exp_q.size() == 1) ? 1 : 0);
                    checkOutput("result", act, exp_q.pop_front());
                end
            end
            if (bus.frame_done) fd_cnt++;
        end
    end

    task automatic sendPixel(input int data, input bit sof);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(data);
        bus.in_sof   = sof;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (t == 999) begin
                total++;
                bad++;
                $display("[TB] FAIL in_ready_timeout: actual=0 required=1");
            end
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        if (rand_ready && ($urandom_range(0, 2) == 0)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic writeCoef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_data = CW'(val);
        @(posedge clk);
        #1;
        bus.coef_we   = 1'b0;
    endtask

    task automatic runFrame(input int junk, input int restart, input int midwrite);
        for (int n = 0; n < junk; n++) sendPixel(200, 1'b0);
        for (int n = 0; n < restart; n++) sendPixel(int'($urandom_range(0, 255)), n == 0);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (midwrite != 0 && r * NC + c == 20) writeCoef(4, 100);
                sendPixel(img[r][c], r == 0 && c == 0);
            end
        end
    endtask

    task automatic waitDrain(input int want);
        for (int t = 0; t < 3000 && got_cnt < want; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic startCollect();
        buildExpected();
        got_cnt    = 0;
        fd_cnt     = 0;
        first_val  = 0;
        last_val   = 0;
        collecting = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int k = 0; k < NTAP; k++) begin
            case (v.coef_mode)
                0:       cf[k] = 1;
                1:       cf[k] = (k == 4) ? 1 : 0;
                2:       cf[k] = -1;
                default: cf[k] = int'($urandom_range(0, 255)) - 128;
            endcase
            writeCoef(k, cf[k]);
        end
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                case (v.pix_mode)
                    0:       img[r][c] = 1;
                    1:       img[r][c] = r * NC + c;
                    2:       img[r][c] = 255;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
        rand_ready = (v.rnd_ready != 0);
        startCollect();
        runFrame(v.junk, v.restart, v.midwrite);
        waitDrain(v.exp_count);
        collecting = 1'b0;
        rand_ready = 1'b0;
        checkOutput({v.name, "_count"}, got_cnt, v.exp_count);
        checkOutput({v.name, "_frame_done"}, fd_cnt, v.exp_fd);
        if (v.fixed != 0) begin
            checkOutput({v.name, "_first"}, first_val, v.exp_first);
            checkOutput({v.name, "_last"}, last_val, v.exp_last);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"ones",        0, 0, 0, 0, 0,  0, 24, 1, 1, 9, 9};
        vecs[1] = '{"center_tap",  1, 1, 0, 0, 0,  0, 24, 1, 1, 9, 38};
`ifdef CONV2D_RELU_EN
        vecs[2] = '{"neg_sat",     2, 2, 0, 0, 0,  0, 24, 1, 1, 0, 0};
`else
        vecs[2] = '{"neg_sat",     2, 2, 0, 0, 0,  0, 24, 1, 1, -2295, -2295};
`endif
        vecs[3] = '{"ones_stall",  0, 0, 1, 0, 0,  0, 24, 1, 1, 9, 9};
        vecs[4] = '{"random",      3, 3, 1, 3, 10, 0, 24, 1, 0, 0, 0};
        vecs[5] = '{"coef_locked", 0, 0, 0, 0, 0,  1, 24, 1, 1, 9, 9};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        ready_level   = 1'b0;
        reset         = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_frame_done", int'(bus.frame_done), 0);
        checkOutput("reset_out_data", int'(bus.out_data), 0);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        ready_level = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %0d: %s", v, vecs[v].name);
            applyStimulus(vecs[v]);
        end

        $display("[TB] abort sequence");
        for (int k = 0; k < NTAP; k++) writeCoef(k, 1);
        for (int n = 0; n < 20; n++) sendPixel(3, n == 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        checkOutput("abort_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Coefficients return to zero after reset, so the clean frame yields all-zero results.
        for (int k = 0; k < NTAP; k++) cf[k] = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                img[r][c] = 1;
        startCollect();
        runFrame(0, 0, 0);
        waitDrain(24);
        collecting = 1'b0;
        checkOutput("abort_count", got_cnt, 24);
        checkOutput("abort_frame_done", fd_cnt, 1);
        checkOutput("abort_last", last_val, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 Parameter NUM_COL, default 8, image width in pixels (>= KSIZE).
REQ-002 Parameter NUM_ROW, default 6, image height in pixels (>= KSIZE).
REQ-003 Parameter KSIZE, default 3, square window dimension (2..7).
REQ-004 Parameter DATA_WIDTH, default 8, unsigned pixel width.
REQ-005 Parameter COEF_WIDTH, default 8, signed coefficient width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_valid / in_ready  input / output  1 / 1  pixel stream handshake.
REQ-009 in_data  input  DATA_WIDTH  pixel, row-major order.
REQ-010 in_sof  input  1  marks the first pixel of a frame; sampled with in_valid.
REQ-011 coef_we / coef_addr / coef_data  input  1 / clog2(KSIZE*KSIZE) / COEF_WIDTH  coefficient write port.
REQ-012 out_valid / out_ready  output / input  1 / 1  result stream handshake.
REQ-013 out_data  output  ACC_W  signed result; ACC_W = DATA_WIDTH+COEF_WIDTH+1+clog2(KSIZE*KSIZE).
REQ-014 frame_done  output  1  one-cycle pulse when the last result of a frame is accepted.

Function
REQ-015 A pixel is accepted when in_valid and in_ready are both 1; in_ready = !out_valid || out_ready.
REQ-016 States: IDLE, ACTIVE; IDLE->ACTIVE on accepted pixel with in_sof=1; accepted pixels without in_sof in IDLE are dropped.
REQ-017 ACTIVE->IDLE on acceptance of pixel (NUM_ROW-1, NUM_COL-1); an accepted in_sof in ACTIVE restarts counters at (0,0) and flushes window contents.
REQ-018 Col/row counters advance on each accepted pixel; col wraps at NUM_COL-1 and increments row.
REQ-019 KSIZE-1 line buffers of NUM_COL entries plus a KSIZE x KSIZE window shift register hold the neighbourhood; window shifts left one column per accepted pixel.
REQ-020 A result is produced for every accepted pixel with row >= KSIZE-1 and col >= KSIZE-1: (NUM_COL-KSIZE+1)*(NUM_ROW-KSIZE+1) results per frame, no padding.
REQ-021 Result = sum over i,j of window[i][j]*coef[i*KSIZE+j], window[0][0] the oldest row/column; pixels zero-extended, full-precision signed arithmetic, no overflow possible at ACC_W.
REQ-022 Latency: out_valid asserts the cycle after the producing pixel is accepted; out_data held stable while out_valid && !out_ready.
REQ-023 Coefficient writes take effect only in IDLE; writes in ACTIVE are ignored.
REQ-024 frame_done pulses in the cycle the frame's final result is accepted; simultaneous in_sof acceptance is still honoured.

Reset
REQ-025 Reset clears state to IDLE, counters, window, out_valid, out_data, frame_done to 0; in_ready reads 1.
REQ-026 Coefficients reset to 0; line buffer contents need not be reset.
REQ-027 Reset mid-frame discards the frame; no result or frame_done is produced for it.

Configuration
REQ-028 With CONV2D_RELU_EN defined, negative results are clamped to 0 before the output register; without it, signed results pass unchanged.

Structure
REQ-029 A shared package holds ACC_W derivation, the state enum and clog2 helper.
REQ-030 One sub-module, conv2d_linebuf (single line buffer, one write/read per accepted pixel), instantiated KSIZE-1 times.

Verification (NUM_COL=8, NUM_ROW=6, KSIZE=3, DATA_WIDTH=8, COEF_WIDTH=8)
REQ-031 All coefs 1, all pixels 1, out_ready=1 -> 24 results each 9, frame_done once.
REQ-032 Coef[4]=1 else 0, pixel = row*8+col -> result k (row r>=2, col c>=2) equals (r-1)*8+(c-1).
REQ-033 All coefs -1, all pixels 255 -> -2295 without CONV2D_RELU_EN, 0 with it.
REQ-034 out_ready toggled randomly 50% -> identical 24-result sequence to REQ-031, no loss or duplication.
REQ-035 Reset asserted after 20 pixels, then full frame -> exactly 24 results, none from aborted frame; coef write in ACTIVE has no effect.
